// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding and
// default datapath parameters.
package cpu_pkg;

  localparam int          DEFAULT_WIDTH        = 16;
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    FETCH,
    EXEC,
    FAULT
  } state_t;

endpackage

// File: rtl/fetch_timeout.sv
// Wait-cycle counter for instruction fetch: cleared outside FETCH, counts
// unacknowledged FETCH cycles, flags the last permitted wait cycle.
module fetch_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_clr,
  input  logic I_inc,
  output logic O_expired
);

  logic [7:0] count_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      count_q <= '0;
    end else if (I_clr) begin
      count_q <= '0;
    end else if (I_inc) begin
      count_q <= count_q + 8'd1;
    end
  end

  // High during the TIMEOUT-th waiting cycle; a missing ack now means fault.
  assign O_expired = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: drives the external PC register, issues
// instruction fetches, hands words to execute and traps on fetch timeout.
module pc_seq import cpu_pkg::*; #(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int               TIMEOUT      = 15
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_run,
  input  logic [WIDTH-1:0] I_pc,
  output logic             O_pc_enable,
  output logic             O_pc_write,
  output logic [WIDTH-1:0] O_pc_in,
  output logic             O_mem_req,
  output logic [WIDTH-1:0] O_mem_addr,
  input  logic             I_mem_ack,
  input  logic [15:0]      I_mem_data,
  output logic [15:0]      O_instr,
  output logic             O_instr_valid,
  input  logic             I_exec_done,
  input  logic             I_branch_taken,
  input  logic [WIDTH-1:0] I_branch_target,
  output logic             O_fault,
  output state_t           O_state
);

  // Fetch handshake: O_mem_req is held with a stable O_mem_addr until the
  // first cycle I_mem_ack is high; that cycle transfers I_mem_data and the
  // request drops at the next edge. I_mem_ack outside a request is ignored.

  state_t state_q, state_d;
  logic   started_q;
  logic   cnt_inc, cnt_expired;
  logic   accept;

  assign accept  = (state_q == FETCH) && I_mem_ack;
  assign O_state = state_q;

  fetch_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timeout (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_clr     (state_q != FETCH),
    .I_inc     (cnt_inc),
    .O_expired (cnt_expired)
  );

  // started_q holds INIT inert until the first edge after reset release.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q       <= INIT;
      started_q     <= 1'b0;
      O_instr       <= '0;
      O_instr_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      started_q     <= 1'b1;
      O_instr_valid <= accept;
      if (accept) begin
        O_instr <= I_mem_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    O_pc_enable = 1'b0;
    O_pc_write  = 1'b0;
    O_pc_in     = '0;
    O_mem_req   = 1'b0;
    O_mem_addr  = '0;
    O_fault     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      INIT: begin
        if (started_q) begin
          O_pc_enable = 1'b1;
          O_pc_write  = 1'b1;
          O_pc_in     = RESET_VECTOR;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        if (I_run) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        O_mem_req  = 1'b1;
        O_mem_addr = I_pc;
        if (I_mem_ack) begin
          state_d = EXEC;
        end else begin
          cnt_inc = 1'b1;
          if (cnt_expired) begin
            state_d = FAULT;
          end
        end
      end
      EXEC: begin
        if (I_exec_done) begin
          O_pc_enable = 1'b1;
          O_pc_write  = I_branch_taken;
          if (I_branch_taken) begin
            O_pc_in = I_branch_target;
          end
          state_d = I_run ? FETCH : IDLE;
        end
      end
      FAULT: begin
        O_fault = 1'b1;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios with literal expectations
// followed by randomized traffic checked against a behavioural model.
module tb_pc_seq;
  import cpu_pkg::*;

  localparam int             W  = 16;
  localparam int             TO = 4;
  localparam logic [W-1:0]   RV = 16'h0000;

  localparam int M_PEND = 0, M_INIT = 1, M_IDLE = 2, M_FETCH = 3, M_EXEC = 4, M_FAULT = 5;

  logic         I_clk = 1'b0;
  logic         I_rst_n = 1'b0;
  logic         I_run = 1'b0;
  logic [W-1:0] I_pc;
  logic         O_pc_enable, O_pc_write;
  logic [W-1:0] O_pc_in;
  logic         O_mem_req;
  logic [W-1:0] O_mem_addr;
  logic         I_mem_ack = 1'b0;
  logic [15:0]  I_mem_data = '0;
  logic [15:0]  O_instr;
  logic         O_instr_valid;
  logic         I_exec_done = 1'b0;
  logic         I_branch_taken = 1'b0;
  logic [W-1:0] I_branch_target = '0;
  logic         O_fault;
  state_t       dbg_state;

  // ---------------- clock / reset / environment ----------------
  always #5 I_clk = ~I_clk;

  // External PC register steered by the sequencer; it has no reset of its own.
  logic [W-1:0] pc_reg = 16'hDEAD;
  assign I_pc = pc_reg;
  always @(posedge I_clk) begin
    if (O_pc_enable) pc_reg <= O_pc_write ? O_pc_in : pc_reg + 16'd1;
  end

  pc_seq #(
    .WIDTH        (W),
    .RESET_VECTOR (RV),
    .TIMEOUT      (TO)
  ) dut (
    .I_clk           (I_clk),
    .I_rst_n         (I_rst_n),
    .I_run           (I_run),
    .I_pc            (I_pc),
    .O_pc_enable     (O_pc_enable),
    .O_pc_write      (O_pc_write),
    .O_pc_in         (O_pc_in),
    .O_mem_req       (O_mem_req),
    .O_mem_addr      (O_mem_addr),
    .I_mem_ack       (I_mem_ack),
    .I_mem_data      (I_mem_data),
    .O_instr         (O_instr),
    .O_instr_valid   (O_instr_valid),
    .I_exec_done     (I_exec_done),
    .I_branch_taken  (I_branch_taken),
    .I_branch_target (I_branch_target),
    .O_fault         (O_fault),
    .O_state         (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_mode = M_PEND;
  int           m_waited = 0;
  logic [15:0]  m_instr = '0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_pc = 16'hDEAD;
  logic [15:0]  exp_q[$];

  initial forever begin
    @(posedge I_clk or negedge I_rst_n);
    if (!I_rst_n) begin
      m_mode   = M_PEND;
      m_waited = 0;
      m_instr  = '0;
      m_valid  = 1'b0;
      exp_q.delete();
    end else begin
      m_valid = 1'b0;
      case (m_mode)
        M_PEND: m_mode = M_INIT;
        M_INIT: begin m_pc = RV; m_mode = M_IDLE; end
        M_IDLE: if (I_run) begin m_mode = M_FETCH; m_waited = 0; end
        M_FETCH: begin
          if (I_mem_ack) begin
            m_instr = I_mem_data;
            m_valid = 1'b1;
            exp_q.push_back(I_mem_data);
            m_mode  = M_EXEC;
          end else begin
            m_waited++;
            if (m_waited >= TO) m_mode = M_FAULT;
          end
        end
        M_EXEC: begin
          if (I_exec_done) begin
            m_pc     = I_branch_taken ? I_branch_target : m_pc + 16'd1;
            m_mode   = I_run ? M_FETCH : M_IDLE;
            m_waited = 0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial forever begin
    logic fire;
    @(negedge I_clk);
    fire = (m_mode == M_EXEC) && I_exec_done;
    chk("pc_enable", O_pc_enable, (m_mode == M_INIT) || fire);
    chk("pc_write", O_pc_write, (m_mode == M_INIT) || (fire && I_branch_taken));
    if (!I_rst_n || m_mode == M_PEND) chk("pc_in_reset", O_pc_in, 0);
    else if (m_mode == M_INIT) chk("pc_in_init", O_pc_in, RV);
    else if (fire && I_branch_taken) chk("pc_in_branch", O_pc_in, I_branch_target);
    chk("mem_req", O_mem_req, m_mode == M_FETCH);
    if (m_mode == M_FETCH) chk("mem_addr", O_mem_addr, m_pc);
    chk("instr", O_instr, m_instr);
    chk("instr_valid", O_instr_valid, m_valid);
    chk("fault", O_fault, m_mode == M_FAULT);
    chk("state_fault", dbg_state == FAULT, m_mode == M_FAULT);
    chk("pc_reg", pc_reg, m_pc);
    if (O_instr_valid) begin
      if (exp_q.size() == 0) chk("sb_unexpected_valid", 1, 0);
      else chk("sb_instr", O_instr, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic run, input logic ack, input logic [15:0] data,
                     input logic done, input logic br, input logic [15:0] tgt);
    @(posedge I_clk);
    #1;
    I_run = run; I_mem_ack = ack; I_mem_data = data;
    I_exec_done = done; I_branch_taken = br; I_branch_target = tgt;
    @(negedge I_clk);
  endtask

  task automatic reset_pulse();
    @(posedge I_clk);
    #2 I_rst_n = 1'b0;
    @(posedge I_clk);
    #2 I_rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish by t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int fault_age;
    fault_age = 0;
    repeat (3) @(negedge I_clk);
    chk("rst_pc_enable", O_pc_enable, 0);
    chk("rst_mem_req", O_mem_req, 0);
    chk("rst_instr", O_instr, 0);
    chk("rst_fault", O_fault, 0);
    chk("rst_pc_in", O_pc_in, 0);
    @(posedge I_clk);
    #2 I_rst_n = 1'b1;

    // first fetch, ack on third wait cycle
    cyc(1, 0, 0, 0, 0, 0);
    chk("init_en", O_pc_enable, 1); chk("init_wr", O_pc_write, 1); chk("init_pc_in", O_pc_in, 16'h0000);
    cyc(1, 0, 0, 0, 0, 0);
    chk("idle_en", O_pc_enable, 0); chk("idle_req", O_mem_req, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("f1_req", O_mem_req, 1); chk("f1_addr", O_mem_addr, 16'h0000);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 16'hA5A5, 0, 0, 0);
    chk("f3_addr", O_mem_addr, 16'h0000); chk("f3_valid", O_instr_valid, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("x1_instr", O_instr, 16'hA5A5); chk("x1_valid", O_instr_valid, 1); chk("x1_en", O_pc_enable, 0);
    cyc(1, 0, 0, 1, 1, 16'h0004);
    chk("x2_valid", O_instr_valid, 0); chk("x2_wr", O_pc_write, 1); chk("x2_pc_in", O_pc_in, 16'h0004);

    // sequential increment from 4
    cyc(1, 1, 16'h1111, 0, 0, 0);
    chk("f_at4", O_mem_addr, 16'h0004);
    cyc(1, 0, 0, 1, 0, 0);
    chk("inc_en", O_pc_enable, 1); chk("inc_wr", O_pc_write, 0);
    cyc(1, 1, 16'h2222, 0, 0, 0);
    chk("f_at5", O_mem_addr, 16'h0005);

    // branch in first exec cycle
    cyc(1, 0, 0, 1, 1, 16'h0100);
    chk("br_valid", O_instr_valid, 1); chk("br_wr", O_pc_write, 1); chk("br_pc_in", O_pc_in, 16'h0100);

    // run dropped mid-fetch
    cyc(0, 0, 0, 0, 0, 0);
    chk("f_at100", O_mem_addr, 16'h0100); chk("f_at100_req", O_mem_req, 1);
    cyc(0, 1, 16'h3333, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("stop_en", O_pc_enable, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stop_req", O_mem_req, 0); chk("stop_pc", I_pc, 16'h0101);
    cyc(0, 1, 16'h7777, 1, 1, 16'h0BAD);
    chk("stray_req", O_mem_req, 0); chk("stray_en", O_pc_enable, 0);

    // wrap at FFFF, then async reset mid-fetch
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 16'h4444, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 16'hFFFF);
    cyc(1, 1, 16'h5555, 0, 0, 0);
    chk("f_atffff", O_mem_addr, 16'hFFFF);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("wrap_addr", O_mem_addr, 16'h0000); chk("wrap_req", O_mem_req, 1);
    #2 I_rst_n = 1'b0;
    #1 chk("async_req", O_mem_req, 0);
    chk("async_en", O_pc_enable, 0);
    @(posedge I_clk);
    #2 I_rst_n = 1'b1;

    // fetch timeout
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("to_f4_fault", O_fault, 0); chk("to_f4_req", O_mem_req, 1);
    cyc(1, 1, 16'h8888, 1, 0, 0);
    chk("to_fault", O_fault, 1); chk("to_req", O_mem_req, 0); chk("to_en", O_pc_enable, 0);
    repeat (3) cyc(1, 1, 16'h9999, 1, 1, 16'h0040);
    chk("to_sticky", O_fault, 1); chk("to_sticky_en", O_pc_enable, 0);
    reset_pulse();

    // ack on the last permitted wait cycle wins
    cyc(1, 0, 0, 0, 0, 0);
    chk("post_rst_fault", O_fault, 0);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 16'h6666, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("late_ack_fault", O_fault, 0); chk("late_ack_instr", O_instr, 16'h6666);
    chk("late_ack_valid", O_instr_valid, 1);
    cyc(0, 0, 0, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (m_mode == M_FAULT) begin
        fault_age++;
        if (fault_age > 3) begin
          reset_pulse();
          fault_age = 0;
        end
      end else if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
      end
      cyc($urandom_range(0, 7) != 0,
          $urandom_range(0, 9) < 5,
          16'($urandom),
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0,
          ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
